// File: rtl/triangle_rasterizer_pkg.sv
// Shared types for the triangle rasterizer: fixed-point vectors, FSM states
// and the fixed-point to integer-pixel helper.
package triangle_rasterizer_pkg;

    typedef logic signed [31:0] FixedPoint_t;

    typedef struct packed {
        FixedPoint_t x;
        FixedPoint_t y;
        FixedPoint_t z;
        FixedPoint_t w;
    } Vector4_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } RasterState_t;

    localparam int EDGE_W = 48;

    // Floor of a signed 16.16 value: the integer half, already sign-carrying.
    function automatic logic signed [15:0] fx_to_int(input FixedPoint_t v);
        return v[31:16];
    endfunction

endpackage

// File: rtl/triangle_rasterizer_edge_function.sv
// Combinational edge function E_ab(p) = (px-ax)*(by-ay) - (py-ay)*(bx-ax).
// Operands are sign-extended to the full edge width before any arithmetic.
module edge_function
    import triangle_rasterizer_pkg::*;
#(
    parameter int COORD_W = 16
) (
    input  logic signed [COORD_W-1:0] i_ax,
    input  logic signed [COORD_W-1:0] i_ay,
    input  logic signed [COORD_W-1:0] i_bx,
    input  logic signed [COORD_W-1:0] i_by,
    input  logic signed [COORD_W-1:0] i_px,
    input  logic signed [COORD_W-1:0] i_py,
    output logic signed [EDGE_W-1:0]  o_e
);

    logic signed [EDGE_W-1:0] w_dpx, w_dpy, w_dbx, w_dby;

    always_comb begin
        w_dpx = EDGE_W'(i_px) - EDGE_W'(i_ax);
        w_dpy = EDGE_W'(i_py) - EDGE_W'(i_ay);
        w_dbx = EDGE_W'(i_bx) - EDGE_W'(i_ax);
        w_dby = EDGE_W'(i_by) - EDGE_W'(i_ay);
        o_e   = (w_dpx * w_dby) - (w_dpy * w_dbx);
    end

endmodule

// File: rtl/triangle_rasterizer.sv
// Flat-shaded triangle rasterizer: captures one triangle, scans its
// screen-clamped bounding box and streams covered pixels over ready/valid.
module triangle_rasterizer
    import triangle_rasterizer_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int COORD_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  Vector4_t           i_v1,
    input  Vector4_t           i_v2,
    input  Vector4_t           i_v3,
    input  Vector4_t           i_c1,
    input  Vector4_t           i_c2,
    input  Vector4_t           i_c3,
    output logic               o_ready,
    output logic               o_pixel_valid,
    input  logic               i_pixel_ready,
    output logic [COORD_W-1:0] o_pixel_x,
    output logic [COORD_W-1:0] o_pixel_y,
    output Vector4_t           o_pixel_colour,
    output logic               o_triangle_done,
    output logic [2:0]         o_debug_state
);

    localparam logic signed [COORD_W-1:0] LP_XLIM = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic signed [COORD_W-1:0] LP_YLIM = COORD_W'(SCREEN_HEIGHT - 1);
    localparam logic signed [COORD_W-1:0] LP_ONE  = COORD_W'(1);

    RasterState_t r_state;
    logic signed [COORD_W-1:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
    logic signed [COORD_W-1:0] r_xmin, r_xmax, r_ymax;
    logic signed [COORD_W-1:0] r_cx, r_cy;

    logic signed [EDGE_W-1:0]  w_e12, w_e23, w_e31;
    logic signed [COORD_W-1:0] w_px12, w_py12;
    logic signed [COORD_W-1:0] w_bxmin, w_bxmax, w_bymin, w_bymax;
    logic w_inside, w_empty, w_advance, w_unused;

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] a,
                                                       input logic signed [COORD_W-1:0] b,
                                                       input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // The E_12 instance doubles as the area evaluator (point = v3) during SETUP.
    assign w_px12 = (r_state == ST_SETUP) ? r_x3 : r_cx;
    assign w_py12 = (r_state == ST_SETUP) ? r_y3 : r_cy;

    edge_function #(.COORD_W(COORD_W)) u_e12 (
        .i_ax(r_x1), .i_ay(r_y1), .i_bx(r_x2), .i_by(r_y2),
        .i_px(w_px12), .i_py(w_py12), .o_e(w_e12)
    );
    edge_function #(.COORD_W(COORD_W)) u_e23 (
        .i_ax(r_x2), .i_ay(r_y2), .i_bx(r_x3), .i_by(r_y3),
        .i_px(r_cx), .i_py(r_cy), .o_e(w_e23)
    );
    edge_function #(.COORD_W(COORD_W)) u_e31 (
        .i_ax(r_x3), .i_ay(r_y3), .i_bx(r_x1), .i_by(r_y1),
        .i_px(r_cx), .i_py(r_cy), .o_e(w_e31)
    );

    assign w_inside = (!w_e12[EDGE_W-1] && !w_e23[EDGE_W-1] && !w_e31[EDGE_W-1]) ||
                      ((w_e12[EDGE_W-1] || w_e12 == '0) &&
                       (w_e23[EDGE_W-1] || w_e23 == '0) &&
                       (w_e31[EDGE_W-1] || w_e31 == '0));

    // Only the low bound is lifted to 0 and only the high bound is cut to the
    // screen edge, so an off-screen box naturally ends up with min > max.
    always_comb begin
        w_bxmin = min3(r_x1, r_x2, r_x3);
        w_bxmax = max3(r_x1, r_x2, r_x3);
        w_bymin = min3(r_y1, r_y2, r_y3);
        w_bymax = max3(r_y1, r_y2, r_y3);
        if (w_bxmin[COORD_W-1]) w_bxmin = '0;
        if (w_bymin[COORD_W-1]) w_bymin = '0;
        if (w_bxmax > LP_XLIM)  w_bxmax = LP_XLIM;
        if (w_bymax > LP_YLIM)  w_bymax = LP_YLIM;
        w_empty = (w_e12 == '0) || (w_bxmin > w_bxmax) || (w_bymin > w_bymax);
    end

    assign w_advance       = !o_pixel_valid || i_pixel_ready;
    assign o_ready         = (r_state == ST_IDLE);
    assign o_triangle_done = (r_state == ST_DONE);
    assign o_debug_state   = r_state;
    assign w_unused        = ^{i_c2, i_c3, i_v1, i_v2, i_v3};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            {r_x1, r_y1, r_x2, r_y2, r_x3, r_y3} <= '0;
            {r_xmin, r_xmax, r_ymax, r_cx, r_cy} <= '0;
            o_pixel_valid  <= 1'b0;
            o_pixel_x      <= '0;
            o_pixel_y      <= '0;
            o_pixel_colour <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_valid) begin
                    r_x1 <= COORD_W'(fx_to_int(i_v1.x));
                    r_y1 <= COORD_W'(fx_to_int(i_v1.y));
                    r_x2 <= COORD_W'(fx_to_int(i_v2.x));
                    r_y2 <= COORD_W'(fx_to_int(i_v2.y));
                    r_x3 <= COORD_W'(fx_to_int(i_v3.x));
                    r_y3 <= COORD_W'(fx_to_int(i_v3.y));
                    o_pixel_colour <= i_c1;
                    r_state <= ST_SETUP;
                end
                ST_SETUP: begin
                    r_xmin  <= w_bxmin;
                    r_xmax  <= w_bxmax;
                    r_ymax  <= w_bymax;
                    r_cx    <= w_bxmin;
                    r_cy    <= w_bymin;
                    r_state <= w_empty ? ST_DONE : ST_SCAN;
                end
                ST_SCAN: if (w_advance) begin
                    o_pixel_valid <= w_inside;
                    if (w_inside) begin
                        o_pixel_x <= r_cx;
                        o_pixel_y <= r_cy;
                    end
                    if (r_cx == r_xmax) begin
                        if (r_cy == r_ymax) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cx <= r_xmin;
                            r_cy <= r_cy + LP_ONE;
                        end
                    end else begin
                        r_cx <= r_cx + LP_ONE;
                    end
                end
                ST_DRAIN: if (w_advance) begin
                    o_pixel_valid <= 1'b0;
                    r_state       <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
